compress_seq: RTL and testbench



---
 rtl/compress_pkg.sv | 24 ++
 rtl/compress_seq_regs.sv | 108 ++++++++++
 rtl/compress_seq.sv | 119 +++++++++++
 tb/tb_compress_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/compress_pkg.sv
// Shared types and register map for the compression sequencer.
package compress_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DONE_ST
  } state_t;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_CONT   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_TMO  = 2;

  localparam logic [31:0] OFF_CTRL   = 32'd0;
  localparam logic [31:0] OFF_STATUS = 32'd1;
  localparam logic [31:0] OFF_WCNT   = 32'd2;

endpackage

// File: rtl/compress_seq_regs.sv
// CPU-visible CTRL/STATUS/WCNT registers: decode, sticky flags with W1C, read mux.
// Optional COMPRESS_SEQ_IRQ_EN adds CTRL.IRQ_EN and a registered level interrupt.
module compress_seq_regs
  import compress_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000C008,
  parameter int          FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic              re,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              hit,
  input  logic              busy,
  input  logic [FCNT_W-1:0] fcnt,
  input  logic [9:0]        wcnt,
  input  logic              set_done,
  input  logic              set_tmo,
  input  logic              clr_flags,
  output logic              go_req,
  output logic              abort_req,
  output logic              cont,
  output logic              irq
);

  logic sel_ctrl, sel_stat, sel_wcnt;
  logic wr_ctrl, wr_stat;
  logic done, tmo, irq_en;
  logic done_nxt, tmo_nxt, cont_nxt;
  logic [7:0] fcnt8;

  assign sel_ctrl = (addr == BASE_ADDR + OFF_CTRL);
  assign sel_stat = (addr == BASE_ADDR + OFF_STATUS);
  assign sel_wcnt = (addr == BASE_ADDR + OFF_WCNT);
  assign hit      = re & (sel_ctrl | sel_stat | sel_wcnt);
  assign wr_ctrl  = we & sel_ctrl;
  assign wr_stat  = we & sel_stat;

  assign go_req    = wr_ctrl & wdata[CTRL_GO];
  assign abort_req = wr_ctrl & wdata[CTRL_ABORT];
  assign fcnt8     = 8'(fcnt);

  // Hardware set is applied last so it beats a same-cycle W1C.
  always_comb begin
    done_nxt = done;
    tmo_nxt  = tmo;
    cont_nxt = wr_ctrl ? wdata[CTRL_CONT] : cont;
    if (clr_flags) begin
      done_nxt = 1'b0;
      tmo_nxt  = 1'b0;
    end
    if (wr_stat && wdata[STAT_DONE]) done_nxt = 1'b0;
    if (wr_stat && wdata[STAT_TMO])  tmo_nxt  = 1'b0;
    if (set_done) done_nxt = 1'b1;
    if (set_tmo)  tmo_nxt  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      tmo  <= 1'b0;
      cont <= 1'b0;
    end else begin
      done <= done_nxt;
      tmo  <= tmo_nxt;
      cont <= cont_nxt;
    end
  end

`ifdef COMPRESS_SEQ_IRQ_EN
  logic irq_en_nxt;
  logic unused_wdata;

  assign irq_en_nxt   = wr_ctrl ? wdata[CTRL_IRQ_EN] : irq_en;
  assign unused_wdata = ^wdata[31:4];

  // Built from next-state flags so irq rises with DONE/TMO, not a cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      irq_en <= irq_en_nxt;
      irq    <= irq_en_nxt & (done_nxt | tmo_nxt);
    end
  end
`else
  logic unused_wdata;

  assign irq_en       = 1'b0;
  assign irq          = 1'b0;
  assign unused_wdata = ^wdata[31:3];
`endif

  always_comb begin
    rdata = 32'd0;
    if (sel_ctrl)
      rdata = {28'd0, irq_en, cont, 1'b0, busy};
    else if (sel_stat)
      rdata = {16'd0, fcnt8, 5'd0, tmo, done, busy};
    else if (sel_wcnt)
      rdata = {22'd0, wcnt};
  end

endmodule

// File: rtl/compress_seq.sv
// Capture sequencer: arms on GO/key, starts the compressor on SOF, counts pixel writes.
// Optional COMPRESS_SEQ_IRQ_EN enables the interrupt output (handled in compress_seq_regs).
module compress_seq
  import compress_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000C008,
  parameter int          NPIX        = 784,
  parameter int          TIMEOUT_CYC = 2_000_000,
  parameter int          FCNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic        key_go,
  input  logic        frame_sof,
  input  logic        pix_wr,
  output logic        cmp_start,
  output logic        busy,
  output logic        irq
);

  localparam int             TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [9:0]     NPIX_W   = 10'(NPIX);

  state_t            state;
  logic [9:0]        wcnt;
  logic [TW-1:0]     tmo_cnt;
  logic [FCNT_W-1:0] fcnt;
  logic go_req, abort_req, cont;
  logic start_any, clr_flags, tmo_hit, set_done;

  assign busy      = (state == ARMED) || (state == RUN);
  assign start_any = go_req | key_go;
  assign clr_flags = (state == IDLE) & start_any & ~abort_req;
  assign tmo_hit   = busy & (tmo_cnt == TMO_LAST) & ~abort_req;
  assign set_done  = (state == DONE_ST) & ~abort_req;

  compress_seq_regs #(
    .BASE_ADDR (BASE_ADDR),
    .FCNT_W    (FCNT_W)
  ) u_regs (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .re        (re),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .hit       (hit),
    .busy      (busy),
    .fcnt      (fcnt),
    .wcnt      (wcnt),
    .set_done  (set_done),
    .set_tmo   (tmo_hit),
    .clr_flags (clr_flags),
    .go_req    (go_req),
    .abort_req (abort_req),
    .cont      (cont),
    .irq       (irq)
  );

  // Abort beats timeout beats normal progress; re-arming restarts the per-frame budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmp_start <= 1'b0;
      wcnt      <= 10'd0;
      tmo_cnt   <= '0;
      fcnt      <= '0;
    end else begin
      cmp_start <= 1'b0;
      if (abort_req || tmo_hit) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_any) begin
              state   <= ARMED;
              wcnt    <= 10'd0;
              tmo_cnt <= '0;
            end
          end
          ARMED: begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (frame_sof) begin
              state     <= RUN;
              cmp_start <= 1'b1;
            end
          end
          RUN: begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (pix_wr && (wcnt != NPIX_W)) begin
              wcnt <= wcnt + 10'd1;
              if (wcnt + 10'd1 == NPIX_W) state <= DONE_ST;
            end
          end
          DONE_ST: begin
            fcnt <= fcnt + FCNT_W'(1);
            if (cont) begin
              state   <= ARMED;
              wcnt    <= 10'd0;
              tmo_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_compress_seq.sv
// Scoreboard bench for compress_seq: reads queue expected values, a negedge monitor checks them.
module tb_compress_seq;

  localparam logic [31:0] CTRL_A = 32'h0000C008;
  localparam logic [31:0] STAT_A = 32'h0000C009;
  localparam logic [31:0] WCNT_A = 32'h0000C00A;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        re, we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        key_go, frame_sof, pix_wr;
  logic        cmp_start, busy, irq;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   start_cnt = 0;
  int   s0;
  int   n;
  bit   busy_drop;

  compress_seq #(
    .BASE_ADDR   (32'h0000C008),
    .NPIX        (784),
    .TIMEOUT_CYC (1000),
    .FCNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .re        (re),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .hit       (hit),
    .key_go    (key_go),
    .frame_sof (frame_sof),
    .pix_wr    (pix_wr),
    .cmp_start (cmp_start),
    .busy      (busy),
    .irq       (irq)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts compressor starts and scores every bus read the DUT answers.
  always @(negedge clk) begin
    if (cmp_start) start_cnt++;
    if (hit) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_read", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput(mon_e.name, rdata, mon_e.val);
      end
    end
  end

  task automatic step(input int cycles = 1);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0; wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    sb.push_back('{name, exp});
    addr = a; re = 1'b1;
    step();
    re = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // Optional SOF pulse followed by npix back-to-back pixel writes.
  task automatic applyStimulus(input bit do_sof, input int npix, input bit watch_busy);
    if (do_sof) begin
      frame_sof = 1'b1;
      step();
      frame_sof = 1'b0;
    end
    for (int i = 0; i < npix; i++) begin
      pix_wr = 1'b1;
      if (watch_busy && !busy) busy_drop = 1'b1;
      step();
    end
    pix_wr = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; addr = 32'd0; re = 1'b0; we = 1'b0; wdata = 32'd0;
    key_go = 1'b0; frame_sof = 1'b0; pix_wr = 1'b0; busy_drop = 1'b0;
    step(3);
    rst = 1'b0;
    step();

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_cmp_start", 32'(cmp_start), 32'd0);
    bus_read(CTRL_A, 32'h0, "rst_ctrl");
    bus_read(STAT_A, 32'h0, "rst_status");
    bus_read(WCNT_A, 32'h0, "rst_wcnt");

    $display("[TB] nominal run");
    bus_write(CTRL_A, 32'h1);
    checkOutput("nom_busy_armed", 32'(busy), 32'd1);
    s0 = start_cnt;
    frame_sof = 1'b1;
    checkOutput("nom_no_start_during_sof", 32'(cmp_start), 32'd0);
    step();
    frame_sof = 1'b0;
    checkOutput("nom_start_after_sof", 32'(cmp_start), 32'd1);
    busy_drop = 1'b0;
    applyStimulus(1'b0, 784, 1'b1);
    checkOutput("nom_busy_throughout", 32'(busy_drop), 32'd0);
    step(2);
    checkOutput("nom_start_pulses", 32'(start_cnt - s0), 32'd1);
    checkOutput("nom_busy_after", 32'(busy), 32'd0);
    bus_read(STAT_A, 32'h0102, "nom_status");
    bus_read(WCNT_A, 32'd784, "nom_wcnt");

    $display("[TB] continuous mode");
    do_reset();
    bus_write(CTRL_A, 32'h5);
    s0 = start_cnt;
    busy_drop = 1'b0;
    for (int f = 0; f < 3; f++) begin
      applyStimulus(1'b1, 784, 1'b1);
      step();
      checkOutput("cont_busy_gap", 32'(busy), 32'd1);
    end
    checkOutput("cont_busy_run", 32'(busy_drop), 32'd0);
    checkOutput("cont_start_pulses", 32'(start_cnt - s0), 32'd3);
    bus_read(STAT_A, 32'h0303, "cont_status_armed");
    bus_write(CTRL_A, 32'h2);
    bus_read(STAT_A, 32'h0302, "cont_status_aborted");

    $display("[TB] timeout");
    do_reset();
    bus_write(CTRL_A, 32'h1);
    n = 0;
    while (busy && n < 1200) begin
      step();
      n++;
    end
    checkOutput("tmo_cycles", 32'(n), 32'd1000);
    bus_read(STAT_A, 32'h0004, "tmo_status");
    bus_write(STAT_A, 32'h4);
    bus_read(STAT_A, 32'h0000, "tmo_status_cleared");

    $display("[TB] abort and conflicts");
    do_reset();
    bus_write(CTRL_A, 32'h3);
    checkOutput("go_abort_busy", 32'(busy), 32'd0);
    bus_read(CTRL_A, 32'h0, "go_abort_ctrl");
    s0 = start_cnt;
    addr = CTRL_A; wdata = 32'h1; we = 1'b1; frame_sof = 1'b1;
    step();
    we = 1'b0; wdata = 32'd0; frame_sof = 1'b0;
    step(3);
    checkOutput("go_sof_no_start", 32'(start_cnt - s0), 32'd0);
    checkOutput("go_sof_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 50, 1'b0);
    bus_write(CTRL_A, 32'h1);
    applyStimulus(1'b0, 50, 1'b0);
    checkOutput("go_in_run_no_restart", 32'(start_cnt - s0), 32'd1);
    bus_write(CTRL_A, 32'h2);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    bus_read(WCNT_A, 32'd100, "abort_wcnt");
    bus_read(STAT_A, 32'h0000, "abort_status");

    $display("[TB] key start and ignored strobes");
    do_reset();
    key_go = 1'b1;
    step();
    key_go = 1'b0;
    checkOutput("key_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 5, 1'b0);
    applyStimulus(1'b1, 784, 1'b0);
    bus_write(STAT_A, 32'h2);
    applyStimulus(1'b0, 10, 1'b0);
    step();
    bus_read(WCNT_A, 32'd784, "key_wcnt");
    bus_read(STAT_A, 32'h0102, "key_status_set_wins");

    $display("[TB] irq");
    do_reset();
    bus_write(CTRL_A, 32'h9);
`ifdef COMPRESS_SEQ_IRQ_EN
    bus_read(CTRL_A, 32'h9, "irq_ctrl");
`else
    bus_read(CTRL_A, 32'h1, "irq_ctrl");
`endif
    applyStimulus(1'b1, 784, 1'b0);
    checkOutput("irq_in_done_st", 32'(irq), 32'd0);
    step();
`ifdef COMPRESS_SEQ_IRQ_EN
    checkOutput("irq_after_done", 32'(irq), 32'd1);
`else
    checkOutput("irq_after_done", 32'(irq), 32'd0);
`endif
    bus_write(STAT_A, 32'h2);
    checkOutput("irq_after_w1c", 32'(irq), 32'd0);
    bus_read(STAT_A, 32'h0100, "irq_status_cleared");

    $display("[TB] reset mid-run");
    do_reset();
    bus_write(CTRL_A, 32'h1);
    applyStimulus(1'b1, 30, 1'b0);
    do_reset();
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    bus_read(WCNT_A, 32'd0, "midrst_wcnt");
    bus_read(STAT_A, 32'h0000, "midrst_status");

    step(3);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
